// File: rtl/dac_wave_gen.sv
// dac_wave_gen: sample source for the DAC write sequencer.
// Generates sawtooth / triangle / square / DC codes at a programmable
// period and offers each code on a valid/ready handshake.
// Optional feature macro: WAVE_TRIANGLE_EN (triangle mode with a direction
// register and clamping). Without it, shape 01 behaves as saw.
module dac_wave_gen #(
    parameter int DIV_W    = 16,
    parameter int STEP_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       shape_sel,
    input  logic [DIV_W-1:0] period,
    input  logic [7:0]       dc_code,
    input  logic             step_up,
    input  logic             step_dn,
    input  logic             sample_ready,
    output logic             sample_valid,
    output logic [7:0]       sample_data,
    output logic [4:0]       step_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        OFFER = 2'd2
    } state_t;

    localparam logic [4:0] STEP_MAX_C = 5'(STEP_MAX);

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] cnt_r;
    logic [7:0]       acc_r;
    logic [7:0]       acc_s;
    logic [7:0]       code_s;
    logic [1:0]       shape_q_r;
    logic [4:0]       step_r;
    logic             compute_s;
    logic             handshake_s;
    logic [7:0]       sample_data_r;
    logic             sample_valid_r;

`ifdef WAVE_TRIANGLE_EN
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
    logic       dir_r;
    logic       dir_s;
    logic [8:0] sum_s;
    logic [8:0] step9_s;
    assign step9_s = {4'b0000, step_r};
    assign sum_s   = {1'b0, acc_r} + step9_s;
`else
    logic [7:0] sum_s;
    assign sum_s = acc_r + {3'b000, step_r};
`endif

    assign sample_valid = sample_valid_r;
    assign sample_data  = sample_data_r;
    assign step_out     = step_r;

    // State register of the sample sequencer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus compute and handshake strobes.
    always_comb begin
        state_s     = state_r;
        compute_s   = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_s = IDLE;
                end else if (cnt_r == period) begin
                    compute_s = 1'b1;
                    state_s   = OFFER;
                end else begin
                    state_s = COUNT;
                end
            end
            OFFER: begin
                // valid is always 1 here, so ready alone completes the handshake
                if (sample_ready) begin
                    handshake_s = 1'b1;
                    state_s     = run ? COUNT : IDLE;
                end else begin
                    state_s = OFFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next accumulator value and output code for the sample being computed.
    always_comb begin
        acc_s  = acc_r;
        code_s = acc_r;
`ifdef WAVE_TRIANGLE_EN
        dir_s  = dir_r;
`endif
        if (shape_sel != shape_q_r) begin
            // shape change restarts the waveform from mid-scale, heading up
            acc_s = 8'h80;
`ifdef WAVE_TRIANGLE_EN
            dir_s = DIR_UP;
`endif
            case (shape_sel)
                2'b10:   code_s = 8'hFF;
                2'b11:   code_s = dc_code;
                default: code_s = 8'h80;
            endcase
        end else begin
            case (shape_sel)
                2'b00: begin
                    acc_s  = sum_s[7:0];
                    code_s = sum_s[7:0];
                end
                2'b01: begin
`ifdef WAVE_TRIANGLE_EN
                    if (dir_r == DIR_UP) begin
                        if (sum_s >= 9'd255) begin
                            acc_s = 8'hFF;
                            dir_s = DIR_DN;
                        end else begin
                            acc_s = sum_s[7:0];
                        end
                    end else begin
                        if ({1'b0, acc_r} <= step9_s) begin
                            acc_s = 8'h00;
                            dir_s = DIR_UP;
                        end else begin
                            acc_s = acc_r - {3'b000, step_r};
                        end
                    end
                    code_s = acc_s;
`else
                    acc_s  = sum_s[7:0];
                    code_s = sum_s[7:0];
`endif
                end
                2'b10: begin
                    acc_s  = sum_s[7:0];
                    code_s = sum_s[7] ? 8'hFF : 8'h00;
                end
                2'b11: begin
                    code_s = dc_code;
                end
                default: begin
                    code_s = acc_r;
                end
            endcase
        end
    end

    // Period counter, waveform state and the offered sample registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r          <= {DIV_W{1'b0}};
            acc_r          <= 8'h80;
            shape_q_r      <= 2'b00;
            sample_valid_r <= 1'b0;
            sample_data_r  <= 8'h80;
`ifdef WAVE_TRIANGLE_EN
            dir_r          <= DIR_UP;
`endif
        end else begin
            // counter restarts from zero whenever COUNT is (re)entered
            if (state_r == COUNT) begin
                cnt_r <= cnt_r + DIV_W'(1);
            end else begin
                cnt_r <= {DIV_W{1'b0}};
            end
            if (compute_s) begin
                acc_r          <= acc_s;
                shape_q_r      <= shape_sel;
                sample_data_r  <= code_s;
                sample_valid_r <= 1'b1;
`ifdef WAVE_TRIANGLE_EN
                dir_r          <= dir_s;
`endif
            end else if (handshake_s) begin
                sample_valid_r <= 1'b0;
            end else begin
                sample_valid_r <= sample_valid_r;
            end
        end
    end

    // Step size: saturating up/down, simultaneous pulses cancel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_r <= 5'd1;
        end else if (step_up && !step_dn) begin
            if (step_r < STEP_MAX_C) begin
                step_r <= step_r + 5'd1;
            end else begin
                step_r <= step_r;
            end
        end else if (step_dn && !step_up) begin
            if (step_r > 5'd1) begin
                step_r <= step_r - 5'd1;
            end else begin
                step_r <= step_r;
            end
        end else begin
            step_r <= step_r;
        end
    end

endmodule
